siso_loopback_ctrl: RTL and testbench

//   Sequencer for an external N-deep SISO shift chain. Accepts a W-bit word over a

---
 rtl/siso_loopback_ctrl_pkg.sv | 16 +
 rtl/siso_loopback_ctrl_siso.sv | 36 +++
 rtl/siso_loopback_ctrl.sv | 118 +++++++++++
 tb/tb_siso_loopback_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/siso_loopback_ctrl_pkg.sv
// Shared definitions for the SISO loopback controller and its bench.
//   state_e : controller states (IDLE / RUN / DONE), same 2-bit encodings as
//             the legacy shared include.
//   DEF_N / DEF_W : default chain depth and word width.
package siso_loopback_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned DEF_W = 8;

endpackage

// File: rtl/siso_loopback_ctrl_siso.sv
// siso: N-deep serial-in/serial-out shift chain (the external datapath that
// the loopback controller drives). Instantiated beside the controller.
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active high, clears the chain
//   serial_in  : bit entering stage 0
//   serial_out : bit leaving stage N-1 (N cycles after entry)
module siso #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic serial_out
);

  logic [N-1:0] stage_q;
  logic [N-1:0] stage_d;
  logic [N:0]   shifted;

  // Widened concatenation keeps the shift legal for N == 1.
  always_comb begin
    shifted = {stage_q, serial_in};
    stage_d = shifted[N-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign serial_out = stage_q[N-1];

endmodule

// File: rtl/siso_loopback_ctrl.sv
// siso_loopback_ctrl: loopback/BIST sequencer for an external N-deep SISO chain.
// Accepts a W-bit word, shifts it MSB-first into the chain, recaptures the
// bits from the chain output after N cycles, and returns the recaptured word
// with a mismatch flag.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : word handshake, in_data is the word to send
//   abort             : synchronous abort, honoured in RUN only
//   sr_serial_in      : drive to chain serial_in (0 outside RUN)
//   sr_serial_out     : from chain serial_out
//   out_valid/out_ready : result handshake, out_data recaptured word,
//                       out_err = recaptured != sent
//   busy              : high while in RUN
module siso_loopback_ctrl
  import siso_loopback_ctrl_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         abort,
  output logic         sr_serial_in,
  input  logic         sr_serial_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err,
  output logic         busy
);

  localparam int unsigned CW = $clog2(W + N);
  localparam logic [CW-1:0] CNT_N    = CW'(N);
  localparam logic [CW-1:0] CNT_W    = CW'(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W + N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  tx_q, tx_d;
  logic [W-1:0]  rx_q, rx_d;

  logic [W:0]    rx_shifted;
  logic [W-1:0]  tx_aligned;

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_shifted = {rx_q, sr_serial_out};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          tx_d    = in_data;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          // Bit driven at cnt=c reaches the chain output at cnt=c+N, so
          // capture starts at cnt=N; stale chain contents are never sampled.
          if (cnt_q >= CNT_N) begin
            rx_d = rx_shifted[W-1:0];
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  // Output decode, purely from registered state.
  always_comb begin
    // Left-shifting by cnt puts tx[W-1-cnt] at the MSB.
    tx_aligned   = tx_q << cnt_q;
    in_ready     = (state_q == IDLE);
    busy         = (state_q == RUN);
    out_valid    = (state_q == DONE);
    out_data     = (state_q == DONE) ? rx_q : '0;
    out_err      = (state_q == DONE) && (rx_q != tx_q);
    sr_serial_in = (state_q == RUN) && (cnt_q < CNT_W) && tx_aligned[W-1];
  end

endmodule

// File: tb/tb_siso_loopback_ctrl.sv
// Directed bench for siso_loopback_ctrl at N=4, W=8 with a siso chain in
// loopback; an optional inverter sits between chain output and controller.
module tb_siso_loopback_ctrl;
  import siso_loopback_ctrl_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         chain_rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         abort;
  logic         sr_serial_in;
  logic         sr_serial_out;
  logic         chain_out;
  logic         inv;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;
  logic         busy;

  int unsigned  total  = 0;
  int unsigned  passed = 0;
  logic         sr_log [8];

  always #5 clk = ~clk;

  siso #(.N(N)) u_chain (
    .clk        (clk),
    .rst        (chain_rst),
    .serial_in  (sr_serial_in),
    .serial_out (chain_out)
  );

  assign sr_serial_out = chain_out ^ inv;

  siso_loopback_ctrl #(.N(N), .W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .abort         (abort),
    .sr_serial_in  (sr_serial_in),
    .sr_serial_out (sr_serial_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_err       (out_err),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at a sample point with the controller in IDLE. Sends one word,
  // logs sr_serial_in for the first W cycles of RUN, holds out_ready low for
  // `hold` cycles in DONE, then releases.
  task automatic send(input string tag, input logic [W-1:0] d,
                      input logic [W-1:0] exp_d, input logic exp_e,
                      input int hold);
    int lat;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    lat = 0;
    sr_log[0] = sr_serial_in;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
      if (lat < 8) sr_log[lat] = sr_serial_in;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd12);
    chk({tag, ".out_data"}, 32'(out_data), 32'(exp_d));
    chk({tag, ".out_err"}, 32'(out_err), 32'(exp_e));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_data"}, 32'(out_data), 32'(exp_d));
      chk({tag, ".hold_err"}, 32'(out_err), 32'(exp_e));
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".released"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle_again"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] words [20];
    int sent, rd, last_acc, idle_cnt, ov_cnt;
    logic accept_now;

    rst = 1'b1; chain_rst = 1'b1; in_valid = 1'b0; in_data = '0;
    abort = 1'b0; out_ready = 1'b0; inv = 1'b0;
    tick(); tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    chk("rst.sr_serial_in", 32'(sr_serial_in), 32'd0);
    rst = 1'b0; chain_rst = 1'b0;
    tick();

    // 1: A5 loops back unchanged; serial stream is MSB-first.
    send("t1", 8'hA5, 8'hA5, 1'b0, 0);
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) chk($sformatf("t1.sr_bit%0d", i), 32'(sr_log[i]), 32'(a5[7-i]));

    // 2: inverted return path.
    inv = 1'b1;
    send("t2", 8'h3C, 8'hC3, 1'b1, 0);
    inv = 1'b0;

    // 3: result held for 5 cycles of out_ready=0.
    send("t3", 8'h96, 8'h96, 1'b0, 5);

    // 4: abort at cnt=6, then FF with no flush.
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t4.busy_before_abort", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4.idle_after_abort", 32'(in_ready), 32'd1);
    chk("t4.not_busy", 32'(busy), 32'd0);
    ov_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) ov_cnt++;
    end
    chk("t4.no_out_valid", 32'(ov_cnt), 32'd0);
    abort = 1'b1;
    chk("t4.abort_in_idle_ready", 32'(in_ready), 32'd1);
    tick();
    abort = 1'b0;
    send("t4b", 8'hFF, 8'hFF, 1'b0, 0);

    // 5: controller-only reset at cnt=3.
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t5.sr_before_rst", 32'(sr_serial_in), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5.in_ready", 32'(in_ready), 32'd1);
    chk("t5.busy", 32'(busy), 32'd0);
    chk("t5.sr_serial_in", 32'(sr_serial_in), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    send("t5b", 8'h81, 8'h81, 1'b0, 0);

    // 6: back-to-back traffic.
    for (int i = 0; i < 20; i++) words[i] = 8'($urandom);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = words[0];
    sent = 0; rd = 0; last_acc = 0; idle_cnt = 0;
    for (int cyc = 0; cyc < 400 && rd < 20; cyc++) begin
      if (out_valid) begin
        chk($sformatf("t6.data%0d", rd), 32'(out_data), 32'(words[rd]));
        chk($sformatf("t6.err%0d", rd), 32'(out_err), 32'd0);
        rd++;
      end
      accept_now = in_ready && in_valid;
      if (in_ready && sent < 20) idle_cnt++;
      tick();
      if (accept_now) begin
        if (sent > 0) chk($sformatf("t6.spacing%0d", sent), 32'(cyc - last_acc), 32'd14);
        last_acc = cyc;
        sent++;
        if (sent < 20) in_data = words[sent];
        else in_valid = 1'b0;
      end
    end
    chk("t6.returned", 32'(rd), 32'd20);
    chk("t6.idle_cycles", 32'(idle_cnt), 32'd20);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
